// File: rtl/wb_machine_timer.sv
// RISC-V machine timer (mtime/mtimecmp) and software-interrupt (msip) registers
// behind a classic single-beat Wishbone slave port.
module wb_machine_timer #(
    parameter int ADDR_WIDTH = 8,
    parameter int PRESCALE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tmr_addr,
    input  logic [31:0] tmr_dat_w,
    input  logic [3:0]  tmr_sel,
    input  logic        tmr_we,
    input  logic        tmr_cyc,
    input  logic        tmr_stb,
    input  logic [2:0]  tmr_cti,
    input  logic [1:0]  tmr_bte,
    output logic [31:0] tmr_dat_r,
    output logic        tmr_ack,
    output logic        tmr_err,
    output logic        timer_interrupt,
    output logic        software_interrupt
);

    localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MSIP    = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] OFF_CMP_LO  = ADDR_WIDTH'(8'h08);
    localparam logic [ADDR_WIDTH-1:0] OFF_CMP_HI  = ADDR_WIDTH'(8'h0C);
    localparam logic [ADDR_WIDTH-1:0] OFF_TIME_LO = ADDR_WIDTH'(8'h10);
    localparam logic [ADDR_WIDTH-1:0] OFF_TIME_HI = ADDR_WIDTH'(8'h14);

    typedef enum logic [2:0] {
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI,
        REG_NONE
    } reg_sel_e;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = lanes[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

    logic [63:0]           mtime_r;
    logic [63:0]           mtimecmp_r;
    logic                  msip_r;
    logic [15:0]           prescale_r;
    logic [ADDR_WIDTH-1:0] offset_s;
    reg_sel_e              reg_sel_s;
    logic [31:0]           rd_data_s;
    logic                  accept_s;
    logic                  wr_s;
    logic                  tick_s;
    logic [63:0]           mtime_next_s;
    logic [63:0]           mtime_wr_s;
    logic                  unused_s;

    // Burst type, wrap type and bits outside the slave window have no effect.
    assign unused_s = ^{tmr_cti, tmr_bte, tmr_addr[31:ADDR_WIDTH], tmr_addr[1:0]};

    assign offset_s     = {tmr_addr[ADDR_WIDTH-1:2], 2'b00};
    assign accept_s     = tmr_cyc & tmr_stb & ~tmr_ack & ~tmr_err;
    assign wr_s         = accept_s & tmr_we & (reg_sel_s != REG_NONE);
    assign tick_s       = (prescale_r == PRESCALE_MAX);
    assign mtime_next_s = mtime_r + {63'h0, tick_s};
    assign software_interrupt = msip_r;

    // Offset decode to register select.
    always_comb begin
        reg_sel_s = REG_NONE;
        case (offset_s)
            OFF_MSIP:    reg_sel_s = REG_MSIP;
            OFF_CMP_LO:  reg_sel_s = REG_CMP_LO;
            OFF_CMP_HI:  reg_sel_s = REG_CMP_HI;
            OFF_TIME_LO: reg_sel_s = REG_TIME_LO;
            OFF_TIME_HI: reg_sel_s = REG_TIME_HI;
            default:     reg_sel_s = REG_NONE;
        endcase
    end

    // Read multiplexer, sampled at the accept edge.
    always_comb begin
        rd_data_s = 32'h0;
        case (reg_sel_s)
            REG_MSIP:    rd_data_s = {31'h0, msip_r};
            REG_CMP_LO:  rd_data_s = mtimecmp_r[31:0];
            REG_CMP_HI:  rd_data_s = mtimecmp_r[63:32];
            REG_TIME_LO: rd_data_s = mtime_r[31:0];
            REG_TIME_HI: rd_data_s = mtime_r[63:32];
            default:     rd_data_s = 32'h0;
        endcase
    end

    // Written lanes override the incremented count; the other half keeps counting.
    always_comb begin
        mtime_wr_s = mtime_next_s;
        if (wr_s && reg_sel_s == REG_TIME_LO) begin
            mtime_wr_s[31:0] = merge_lanes(mtime_next_s[31:0], tmr_dat_w, tmr_sel);
        end else if (wr_s && reg_sel_s == REG_TIME_HI) begin
            mtime_wr_s[63:32] = merge_lanes(mtime_next_s[63:32], tmr_dat_w, tmr_sel);
        end else begin
            mtime_wr_s = mtime_next_s;
        end
    end

    // Bus response: one-cycle ack or err pulse per accepted access.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_ack   <= 1'b0;
            tmr_err   <= 1'b0;
            tmr_dat_r <= 32'h0;
        end else begin
            tmr_ack   <= accept_s & (reg_sel_s != REG_NONE);
            tmr_err   <= accept_s & (reg_sel_s == REG_NONE);
            tmr_dat_r <= (accept_s && reg_sel_s != REG_NONE) ? rd_data_s : 32'h0;
        end
    end

    // Prescaler, mtime counter and compare interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_r      <= 16'h0;
            mtime_r         <= 64'h0;
            timer_interrupt <= 1'b0;
        end else begin
            prescale_r      <= tick_s ? 16'h0 : prescale_r + 16'h1;
            mtime_r         <= mtime_wr_s;
            timer_interrupt <= (mtime_r >= mtimecmp_r);
        end
    end

    // Software-writable compare and msip registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_r     <= 1'b0;
        end else if (wr_s) begin
            case (reg_sel_s)
                REG_MSIP:   msip_r <= tmr_sel[0] ? tmr_dat_w[0] : msip_r;
                REG_CMP_LO: mtimecmp_r[31:0] <= merge_lanes(mtimecmp_r[31:0], tmr_dat_w, tmr_sel);
                REG_CMP_HI: mtimecmp_r[63:32] <= merge_lanes(mtimecmp_r[63:32], tmr_dat_w, tmr_sel);
                default:    msip_r <= msip_r;
            endcase
        end else begin
            msip_r <= msip_r;
        end
    end

endmodule
